// File: rtl/exc_pkg.sv
// Shared types and constants for the CP0 exception sequencer.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        MASK,
        RESTORE,
        DFAULT,
        REDIR
    } exc_state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 10;
    localparam int ST_IM_HI = 15;

    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selector: RI > Ov > Sys > interrupt. Reports whether anything is taken and its ExcCode.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       req_ri,
    input  logic       req_ovf,
    input  logic       req_sys,
    input  logic       req_irq,
    output logic       take,
    output logic       is_irq,
    output logic [4:0] code
);

    // NOTE: every output gets a default before the if-chain so no path infers a latch.
    always_comb begin
        take   = 1'b1;
        is_irq = 1'b0;
        code   = EXC_INT;
        if (req_ri) begin
            code = EXC_RI;
        end else if (req_ovf) begin
            code = EXC_OV;
        end else if (req_sys) begin
            code = EXC_SYS;
        end else if (req_irq) begin
            is_irq = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception sequencer: latches events, writes EPC/Cause/Status, then requests a PC redirect.
// Build option: define EXC_IRQ_EN to enable the external interrupt path.
module exc_ctrl
    import exc_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        exc_ri,
    input  logic        exc_ovf,
    input  logic        exc_sys,
    input  logic [5:0]  irq,
    input  logic        instr_done,
    input  logic        eret,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pc_next,
    input  logic [31:0] status_q,
    input  logic [31:0] epc_q,
    input  logic        redirect_ack,
    output logic        EPCWrite,
    output logic        CWrite,
    output logic        SWrite,
    output logic        srst,
    output logic [31:0] epc_d,
    output logic [31:0] cause_d,
    output logic [31:0] status_d,
    output logic        redirect,
    output logic [31:0] pc_target,
    output logic        busy
);

    exc_state_e  state, state_n;
    logic        pend_ri, pend_ovf, pend_sys;
    logic        req_ri, req_ovf, req_sys, irq_cond;
    logic        take, is_irq, take_now;
    logic        clr_ri, clr_ovf, clr_sys;
    logic [4:0]  code, code_q;
    logic [5:0]  irq_snap, irq_q;
    logic [31:0] epc_save, tgt_q, cause_word;

    assign req_ri  = pend_ri  | exc_ri;
    assign req_ovf = pend_ovf | exc_ovf;
    assign req_sys = pend_sys | exc_sys;

`ifdef EXC_IRQ_EN
    assign irq_cond = instr_done & status_q[ST_IE] & ~status_q[ST_EXL]
                    & |(irq & status_q[ST_IM_HI:ST_IM_LO]);
    assign irq_snap = irq;
`else
    logic unused_irq_in;
    assign unused_irq_in = ^{irq, instr_done};
    assign irq_cond      = 1'b0;
    assign irq_snap      = 6'b0;
`endif

    exc_prio_enc u_prio (
        .req_ri  (req_ri),
        .req_ovf (req_ovf),
        .req_sys (req_sys),
        .req_irq (irq_cond),
        .take    (take),
        .is_irq  (is_irq),
        .code    (code)
    );

    assign take_now = (state == IDLE) & take;
    assign clr_ri   = take_now & (code == EXC_RI);
    assign clr_ovf  = take_now & (code == EXC_OV);
    assign clr_sys  = take_now & ~is_irq & (code == EXC_SYS);

    // NOTE: state and captured registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A consumed flag survives only if a fresh pulse of the same kind lands in the same cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend_ri  <= 1'b0;
            pend_ovf <= 1'b0;
            pend_sys <= 1'b0;
        end else begin
            pend_ri  <= clr_ri  ? (pend_ri  & exc_ri)  : req_ri;
            pend_ovf <= clr_ovf ? (pend_ovf & exc_ovf) : req_ovf;
            pend_sys <= clr_sys ? (pend_sys & exc_sys) : req_sys;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            code_q   <= EXC_INT;
            irq_q    <= 6'b0;
            epc_save <= 32'h0;
            tgt_q    <= 32'h0;
        end else begin
            if (take_now) begin
                code_q   <= code;
                irq_q    <= irq_snap;
                epc_save <= is_irq ? pc_next : pc_cur;
            end
            case (state)
                MASK:    tgt_q <= EXC_VECTOR;
                RESTORE: tgt_q <= epc_q;
                DFAULT:  tgt_q <= RESET_VECTOR;
                default: tgt_q <= tgt_q;
            endcase
        end
    end

    assign cause_word = {16'b0, irq_q, 2'b0, 1'b0, code_q, 2'b0};
    assign busy       = (state != IDLE);

    always_comb begin
        state_n   = state;
        EPCWrite  = 1'b0;
        CWrite    = 1'b0;
        SWrite    = 1'b0;
        srst      = 1'b0;
        redirect  = 1'b0;
        epc_d     = 32'h0;
        cause_d   = 32'h0;
        status_d  = 32'h0;
        pc_target = 32'h0;
        case (state)
            IDLE: begin
                // Interrupts only fire with EXL clear, so EXL=1 here means a nested synchronous fault.
                if (take) begin
                    state_n = (is_irq || !status_q[ST_EXL]) ? SAVE : DFAULT;
                end else if (eret) begin
                    state_n = RESTORE;
                end
            end
            SAVE: begin
                EPCWrite = 1'b1;
                CWrite   = 1'b1;
                epc_d    = epc_save;
                cause_d  = cause_word;
                state_n  = MASK;
            end
            MASK: begin
                SWrite   = 1'b1;
                status_d = status_q | 32'h2;
                state_n  = REDIR;
            end
            RESTORE: begin
                SWrite   = 1'b1;
                status_d = status_q & ~32'h2;
                state_n  = REDIR;
            end
            DFAULT: begin
                srst    = 1'b1;
                CWrite  = 1'b1;
                cause_d = cause_word;
                state_n = REDIR;
            end
            REDIR: begin
                redirect  = 1'b1;
                pc_target = tgt_q;
                if (redirect_ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a plan-queue reference model compared every cycle plus directed literal checks.
module tb_exc_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        exc_ri = 1'b0, exc_ovf = 1'b0, exc_sys = 1'b0;
    logic [5:0]  irq = 6'b0;
    logic        instr_done = 1'b0, eret = 1'b0, redirect_ack = 1'b0;
    logic [31:0] pc_cur = 32'h0, pc_next = 32'h0, status_q = 32'h0, epc_q = 32'h0;
    logic        EPCWrite, CWrite, SWrite, srst, redirect, busy;
    logic [31:0] epc_d, cause_d, status_d, pc_target;

    int checks = 0;
    int failures = 0;

    exc_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .exc_ri       (exc_ri),
        .exc_ovf      (exc_ovf),
        .exc_sys      (exc_sys),
        .irq          (irq),
        .instr_done   (instr_done),
        .eret         (eret),
        .pc_cur       (pc_cur),
        .pc_next      (pc_next),
        .status_q     (status_q),
        .epc_q        (epc_q),
        .redirect_ack (redirect_ack),
        .EPCWrite     (EPCWrite),
        .CWrite       (CWrite),
        .SWrite       (SWrite),
        .srst         (srst),
        .epc_d        (epc_d),
        .cause_d      (cause_d),
        .status_d     (status_d),
        .redirect     (redirect),
        .pc_target    (pc_target),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an idle decision expands into a queue of planned output cycles.
    typedef struct {
        bit          epc_we;
        bit          c_we;
        bit          srst;
        bit          redir;
        bit          tgt_epc;
        int          st_op;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] target;
    } step_t;

    step_t       plan[$];
    bit          m_ri = 1'b0, m_ov = 1'b0, m_sy = 1'b0;
    logic [31:0] m_eret_tgt = 32'h0;

    function automatic step_t blank();
        step_t s;
        s.epc_we = 1'b0; s.c_we = 1'b0; s.srst = 1'b0; s.redir = 1'b0; s.tgt_epc = 1'b0;
        s.st_op = 0; s.epc = 32'h0; s.cause = 32'h0; s.target = 32'h0;
        return s;
    endfunction

    task automatic model_step();
        bit          r, o, s, intr, tr, to, ts;
        logic [31:0] code_v, irq_v, cause_v;
        step_t       st;
        if (plan.size() == 0) begin
            r = m_ri | exc_ri;
            o = m_ov | exc_ovf;
            s = m_sy | exc_sys;
            intr = 1'b0;
            irq_v = 32'h0;
`ifdef EXC_IRQ_EN
            intr  = instr_done && status_q[0] && !status_q[1] && ((irq & status_q[15:10]) != 6'd0);
            irq_v = {26'd0, irq};
`endif
            tr = r;
            to = o && !r;
            ts = s && !r && !o;
            if (r || o || s || intr) begin
                code_v  = r ? 32'd10 : (o ? 32'd12 : (s ? 32'd8 : 32'd0));
                cause_v = (irq_v << 10) | (code_v << 2);
                if (!(r || o || s) || !status_q[1]) begin
                    st = blank(); st.epc_we = 1'b1; st.c_we = 1'b1; st.cause = cause_v;
                    st.epc = (r || o || s) ? pc_cur : pc_next;
                    plan.push_back(st);
                    st = blank(); st.st_op = 1; plan.push_back(st);
                    st = blank(); st.redir = 1'b1; st.target = 32'h8000_0180; plan.push_back(st);
                end else begin
                    st = blank(); st.c_we = 1'b1; st.srst = 1'b1; st.cause = cause_v; plan.push_back(st);
                    st = blank(); st.redir = 1'b1; st.target = 32'hBFC0_0000; plan.push_back(st);
                end
            end else if (eret) begin
                st = blank(); st.st_op = 2; plan.push_back(st);
                st = blank(); st.redir = 1'b1; st.tgt_epc = 1'b1; plan.push_back(st);
            end
            m_ri = tr ? (m_ri & exc_ri)  : (m_ri | exc_ri);
            m_ov = to ? (m_ov & exc_ovf) : (m_ov | exc_ovf);
            m_sy = ts ? (m_sy & exc_sys) : (m_sy | exc_sys);
        end else begin
            st = plan[0];
            if (st.redir) begin
                if (redirect_ack) void'(plan.pop_front());
            end else begin
                if (st.st_op == 2) m_eret_tgt = epc_q;
                void'(plan.pop_front());
            end
            m_ri = m_ri | exc_ri;
            m_ov = m_ov | exc_ovf;
            m_sy = m_sy | exc_sys;
        end
    endtask

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            plan.delete();
            m_ri = 1'b0; m_ov = 1'b0; m_sy = 1'b0;
            m_eret_tgt = 32'h0;
        end else begin
            model_step();
        end
    end

    always @(negedge Clk) begin : cmp
        step_t       st;
        logic [31:0] exp_st;
        st = (plan.size() == 0) ? blank() : plan[0];
        exp_st = (st.st_op == 1) ? (status_q | 32'h2) :
                 (st.st_op == 2) ? (status_q & ~32'h2) : 32'h0;
        check_bit("cmp_EPCWrite", EPCWrite, st.epc_we);
        check_bit("cmp_CWrite", CWrite, st.c_we);
        check_bit("cmp_SWrite", SWrite, st.st_op != 0);
        check_bit("cmp_srst", srst, st.srst);
        check_bit("cmp_redirect", redirect, st.redir);
        check_bit("cmp_busy", busy, plan.size() != 0);
        check32("cmp_epc_d", epc_d, st.epc);
        check32("cmp_cause_d", cause_d, st.cause);
        check32("cmp_status_d", status_d, exp_st);
        check32("cmp_pc_target", pc_target, st.redir ? (st.tgt_epc ? m_eret_tgt : st.target) : 32'h0);
    end

    task automatic cycle();
        @(negedge Clk);
        #1;
    endtask

    task automatic finish_seq();
        int n = 0;
        while (redirect !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check_bit("redirect_reached", redirect, 1'b1);
        redirect_ack = 1'b1;
        cycle();
        redirect_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cycle();
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_redirect", redirect, 1'b0);
        check32("reset_pc_target", pc_target, 32'h0);
        Reset = 1'b1;
        cycle();

        // Overflow, ack on the second REDIR cycle.
        status_q = 32'h0000_FC01; pc_cur = 32'h0040_0010; pc_next = 32'h0040_0014;
        exc_ovf = 1'b1;
        cycle();
        exc_ovf = 1'b0;
        check_bit("ovf_save_epcwrite", EPCWrite, 1'b1);
        check32("ovf_save_epc", epc_d, 32'h0040_0010);
        check32("ovf_save_cause", cause_d, 32'h0000_0030);
        cycle();
        check_bit("ovf_mask_swrite", SWrite, 1'b1);
        check32("ovf_mask_status", status_d, 32'h0000_FC03);
        cycle();
        check_bit("ovf_redirect", redirect, 1'b1);
        check32("ovf_target", pc_target, 32'h8000_0180);
        cycle();
        check_bit("ovf_redirect_hold", redirect, 1'b1);
        redirect_ack = 1'b1;
        cycle();
        redirect_ack = 1'b0;
        check_bit("ovf_busy_fall", busy, 1'b0);

        // Simultaneous RI and Sys: RI first, Sys right after returning to IDLE.
        exc_ri = 1'b1; exc_sys = 1'b1;
        cycle();
        exc_ri = 1'b0; exc_sys = 1'b0;
        check32("ri_cause", cause_d, 32'h0000_0028);
        cycle();
        cycle();
        check_bit("ri_redirect", redirect, 1'b1);
        redirect_ack = 1'b1;
        cycle();
        redirect_ack = 1'b0;
        check_bit("ri_idle_gap", busy, 1'b0);
        cycle();
        check_bit("sys_followup_save", EPCWrite, 1'b1);
        check32("sys_followup_cause", cause_d, 32'h0000_0020);
        finish_seq();

        // Interrupt path.
        irq = 6'b000100; status_q = 32'h0000_1001; instr_done = 1'b1; pc_next = 32'h0040_0024;
        cycle();
        irq = 6'b0; instr_done = 1'b0;
`ifdef EXC_IRQ_EN
        check32("irq_epc", epc_d, 32'h0040_0024);
        check32("irq_cause", cause_d, 32'h0000_1000);
        finish_seq();
`else
        check_bit("irq_ignored", busy, 1'b0);
`endif
        irq = 6'b000100; status_q = 32'h0000_1003; instr_done = 1'b1;
        cycle();
        cycle();
        check_bit("irq_exl_blocked", busy, 1'b0);
        irq = 6'b0; instr_done = 1'b0;

        // ERET, then ERET coincident with Sys.
        epc_q = 32'h0040_0028; status_q = 32'h0000_0003;
        eret = 1'b1;
        cycle();
        eret = 1'b0;
        check_bit("eret_swrite", SWrite, 1'b1);
        check32("eret_status", status_d, 32'h0000_0001);
        cycle();
        check32("eret_target", pc_target, 32'h0040_0028);
        epc_q = 32'h1234_5678;
        cycle();
        check32("eret_target_held", pc_target, 32'h0040_0028);
        redirect_ack = 1'b1;
        cycle();
        redirect_ack = 1'b0;
        status_q = 32'h0000_0001;
        eret = 1'b1; exc_sys = 1'b1;
        cycle();
        eret = 1'b0; exc_sys = 1'b0;
        check_bit("eret_sys_epcwrite", EPCWrite, 1'b1);
        check32("eret_sys_cause", cause_d, 32'h0000_0020);
        finish_seq();
        cycle();
        check_bit("eret_dropped", busy, 1'b0);

        // Double fault.
        status_q = 32'h0000_0003;
        exc_ri = 1'b1;
        cycle();
        exc_ri = 1'b0;
        check_bit("df_srst", srst, 1'b1);
        check_bit("df_cwrite", CWrite, 1'b1);
        check_bit("df_no_epcwrite", EPCWrite, 1'b0);
        check_bit("df_no_swrite", SWrite, 1'b0);
        cycle();
        check32("df_target", pc_target, 32'hBFC0_0000);
        redirect_ack = 1'b1;
        cycle();
        redirect_ack = 1'b0;

        // Reset in MASK, then a clean overflow.
        status_q = 32'h0000_FC01;
        exc_ovf = 1'b1;
        cycle();
        exc_ovf = 1'b0;
        cycle();
        check_bit("rst_in_mask", SWrite, 1'b1);
        Reset = 1'b0;
        #1;
        check_bit("rst_swrite_low", SWrite, 1'b0);
        check_bit("rst_busy_low", busy, 1'b0);
        check32("rst_status_d", status_d, 32'h0);
        cycle();
        Reset = 1'b1;
        cycle();
        exc_ovf = 1'b1;
        cycle();
        exc_ovf = 1'b0;
        check32("post_rst_epc", epc_d, 32'h0040_0010);
        check32("post_rst_cause", cause_d, 32'h0000_0030);
        finish_seq();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
